// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, waits WAIT_CYCLES, answers with a strobe.
// Optional macro DMEM_SUBWORD_EN compiles byte/halfword lane selection and load extension.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        StallM
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT       state, stateNext;
  logic [3:0]  waitCnt;
  logic        weQ;
  logic [31:0] addrQ, wdataQ;
  logic [2:0]  funct3Q;
  logic        accept, enterResp, memWe;
  logic        effWe, effErr;
  logic [31:0] effAddr, effWdata;
  logic [2:0]  effFunct3;
  logic [AW-1:0] effIdx;
  logic [31:0] rdWord, ldData, wrMask, wrData;
  logic [31:0] rdataQ;
  logic        errQ;
  logic        unusedAddrBits;
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    StallM    = 1'b0;
    accept    = 1'b0;
    enterResp = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = reset;
        StallM    = reset & req_valid;
        accept    = reset & req_valid;
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (waitCnt == 4'd0) begin
          stateNext = RESP;
          enterResp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge itself, so the live request is used there.
  assign effWe     = (state == IDLE) ? req_we     : weQ;
  assign effAddr   = (state == IDLE) ? req_addr   : addrQ;
  assign effWdata  = (state == IDLE) ? req_wdata  : wdataQ;
  assign effFunct3 = (state == IDLE) ? req_funct3 : funct3Q;
  assign effIdx    = effAddr[AW+1:2];
  assign unusedAddrBits = ^effAddr[31:AW+2];
  assign rdWord    = mem[effIdx];
  assign memWe     = enterResp & effWe & ~effErr;

`ifdef DMEM_SUBWORD_EN
  logic [15:0] laneData;

  always_comb begin
    effErr = 1'b1;
    unique case (effFunct3)
      3'b000, 3'b100: effErr = 1'b0;
      3'b001, 3'b101: effErr = effAddr[0];
      3'b010:         effErr = (effAddr[1:0] != 2'b00);
      default:        effErr = 1'b1;
    endcase
  end

  always_comb begin
    laneData = 16'(rdWord >> {effAddr[1:0], 3'b000});
    wrMask   = 32'hFFFF_FFFF;
    wrData   = effWdata;
    ldData   = rdWord;
    unique case (effFunct3[1:0])
      2'b00: begin
        wrMask = 32'h0000_00FF << {effAddr[1:0], 3'b000};
        wrData = {4{effWdata[7:0]}};
        ldData = effFunct3[2] ? {24'd0, laneData[7:0]} : {{24{laneData[7]}}, laneData[7:0]};
      end
      2'b01: begin
        wrMask = 32'h0000_FFFF << {effAddr[1], 4'b0000};
        wrData = {2{effWdata[15:0]}};
        ldData = effFunct3[2] ? {16'd0, laneData} : {{16{laneData[15]}}, laneData};
      end
      default: ;
    endcase
  end
`else
  assign effErr = (effFunct3 != 3'b010) || (effAddr[1:0] != 2'b00);
  assign wrMask = 32'hFFFF_FFFF;
  assign wrData = effWdata;
  assign ldData = rdWord;
`endif

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= 4'd0;
      weQ     <= 1'b0;
      addrQ   <= 32'd0;
      wdataQ  <= 32'd0;
      funct3Q <= 3'd0;
      rdataQ  <= 32'd0;
      errQ    <= 1'b0;
    end else begin
      if (accept) begin
        weQ     <= req_we;
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        funct3Q <= req_funct3;
        waitCnt <= WAIT_LOAD;
      end else if (state == BUSY && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (enterResp) begin
        errQ   <= effErr;
        rdataQ <= (effWe || effErr) ? 32'd0 : ldData;
      end
    end
  end

  // NOTE: the array has no reset; its contents survive reset and only change through committed stores.
  always_ff @(posedge clk) begin
    if (memWe) mem[effIdx] <= (rdWord & ~wrMask) | (wrData & wrMask);
  end

  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder; three instances cover WAIT_CYCLES = 1, 0 and 3.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rstN      [3];
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [31:0] reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic [2:0]  reqFunct3 [3];
  logic        rspValid  [3];
  logic [31:0] rspRdata  [3];
  logic        rspErr    [3];
  logic        stallM    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(rstN[g]),
      .req_valid(reqValid[g]), .req_ready(reqReady[g]), .req_we(reqWe[g]),
      .req_addr(reqAddr[g]), .req_wdata(reqWdata[g]), .req_funct3(reqFunct3[g]),
      .rsp_valid(rspValid[g]), .rsp_rdata(rspRdata[g]), .rsp_err(rspErr[g]),
      .StallM(stallM[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } expT;

  expT sbQ[$];
  int  errCnt = 0;
  int  chkCnt = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_BAD = 3'b011;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int waitOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic drive(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    reqValid[d]  = 1'b1;
    reqWe[d]     = we;
    reqAddr[d]   = addr;
    reqWdata[d]  = wdata;
    reqFunct3[d] = f3;
  endtask

  task automatic popCompare(input int d);
    expT e;
    if (sbQ.size() == 0) begin
      check("sb.empty", 32'd1, 32'd0);
      return;
    end
    e = sbQ.pop_front();
    check($sformatf("%s.rdata", e.tag), rspRdata[d], e.rdata);
    check($sformatf("%s.err", e.tag), 32'(rspErr[d]), 32'(e.err));
  endtask

  // One complete transaction: drive, confirm acceptance, scramble the bus, wait for the strobe.
  task automatic doReq(input int d, input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] expRdata, input logic expErr);
    expT e;
    int  lat;
    @(negedge clk);
    drive(d, we, addr, wdata, f3);
    #1;
    check($sformatf("%s.ready", tag), 32'(reqReady[d]), 32'd1);
    check($sformatf("%s.stallAcc", tag), 32'(stallM[d]), 32'd1);
    e.rdata = expRdata; e.err = expErr; e.lat = waitOf(d) + 1; e.tag = tag;
    sbQ.push_back(e);
    @(negedge clk);
    reqValid[d]  = 1'b0;
    reqWe[d]     = 1'($urandom);
    reqAddr[d]   = $urandom;
    reqWdata[d]  = $urandom;
    reqFunct3[d] = 3'($urandom);
    lat = 1;
    while (!rspValid[d] && lat < 40) begin
      check($sformatf("%s.stallBusy", tag), 32'(stallM[d]), 32'd1);
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s.valid", tag), 32'(rspValid[d]), 32'd1);
    check($sformatf("%s.lat", tag), lat, e.lat);
    check($sformatf("%s.stallRsp", tag), 32'(stallM[d]), 32'd0);
    popCompare(d);
  endtask

  initial begin
    int sawValid;
    expT e;
    for (int i = 0; i < 3; i++) begin
      rstN[i] = 1'b0; reqValid[i] = 1'b0; reqWe[i] = 1'b0;
      reqAddr[i] = '0; reqWdata[i] = '0; reqFunct3[i] = '0;
    end
    reqValid[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst.ready", 32'(reqReady[0]), 32'd0);
    check("rst.stall", 32'(stallM[0]), 32'd0);
    check("rst.valid", 32'(rspValid[0]), 32'd0);
    check("rst.err", 32'(rspErr[0]), 32'd0);
    check("rst.rdata", rspRdata[0], 32'd0);
    @(negedge clk);
    reqValid[0] = 1'b0;
    for (int i = 0; i < 3; i++) rstN[i] = 1'b1;

    doReq(0, "s1.sw", 1'b1, 32'h10, 32'hDEADBEEF, F_W, 32'd0, 1'b0);
    doReq(0, "s1.lw", 1'b0, 32'h10, 32'd0, F_W, 32'hDEADBEEF, 1'b0);

    doReq(0, "s2.sw", 1'b1, 32'h20, 32'h0, F_W, 32'd0, 1'b0);
`ifdef DMEM_SUBWORD_EN
    doReq(0, "s2.sb",  1'b1, 32'h21, 32'h80, F_B, 32'd0, 1'b0);
    doReq(0, "s2.lb",  1'b0, 32'h21, 32'd0, F_B,  32'hFFFFFF80, 1'b0);
    doReq(0, "s2.lbu", 1'b0, 32'h21, 32'd0, F_BU, 32'h00000080, 1'b0);
    doReq(0, "s2.lh",  1'b0, 32'h20, 32'd0, F_H,  32'hFFFF8000, 1'b0);
    doReq(0, "s2.lw",  1'b0, 32'h20, 32'd0, F_W,  32'h00008000, 1'b0);
`else
    doReq(0, "s2.sb",  1'b1, 32'h21, 32'h80, F_B, 32'd0, 1'b1);
    doReq(0, "s2.lb",  1'b0, 32'h21, 32'd0, F_B,  32'd0, 1'b1);
    doReq(0, "s2.lbu", 1'b0, 32'h21, 32'd0, F_BU, 32'd0, 1'b1);
    doReq(0, "s2.lh",  1'b0, 32'h20, 32'd0, F_H,  32'd0, 1'b1);
    doReq(0, "s2.lw",  1'b0, 32'h20, 32'd0, F_W,  32'd0, 1'b0);
`endif

    doReq(0, "s3.lwMis", 1'b0, 32'h22, 32'd0, F_W, 32'd0, 1'b1);
    doReq(0, "s3.shMis", 1'b1, 32'h13, 32'hFFFF, F_H, 32'd0, 1'b1);
    doReq(0, "s3.badF3", 1'b1, 32'h10, 32'h0, F_BAD, 32'd0, 1'b1);
    doReq(0, "s3.lw10", 1'b0, 32'h10, 32'd0, F_W, 32'hDEADBEEF, 1'b0);
`ifdef DMEM_SUBWORD_EN
    doReq(0, "s3.lw20", 1'b0, 32'h20, 32'd0, F_W, 32'h00008000, 1'b0);
`else
    doReq(0, "s3.lw20", 1'b0, 32'h20, 32'd0, F_W, 32'h00000000, 1'b0);
`endif

    doReq(0, "s6.sw",   1'b1, 32'h400, 32'hA5A5A5A5, F_W, 32'd0, 1'b0);
    doReq(0, "s6.lw0",  1'b0, 32'h0,   32'd0, F_W, 32'hA5A5A5A5, 1'b0);
    doReq(0, "s6.lw410", 1'b0, 32'h410, 32'd0, F_W, 32'hDEADBEEF, 1'b0);

    // Zero wait states with req_valid held: accept and response alternate every cycle.
    doReq(1, "s4.sw", 1'b1, 32'h8, 32'hCAFEF00D, F_W, 32'd0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 32'h8, 32'd0, F_W);
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s4.ready%0d", k), 32'(reqReady[1]), 32'((k % 2) == 0));
      check($sformatf("s4.stall%0d", k), 32'(stallM[1]), 32'((k % 2) == 0));
      check($sformatf("s4.valid%0d", k), 32'(rspValid[1]), 32'((k % 2) == 1));
      if ((k % 2) == 0) begin
        e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.lat = 1; e.tag = $sformatf("s4.lw%0d", k);
        sbQ.push_back(e);
      end else begin
        popCompare(1);
      end
      @(negedge clk);
      #1;
    end
    reqValid[1] = 1'b0;

    // Reset during the wait window must drop the pending store.
    doReq(2, "s5.sw1", 1'b1, 32'h40, 32'h11111111, F_W, 32'd0, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 32'h40, 32'h12345678, F_W);
    #1;
    check("s5.ready", 32'(reqReady[2]), 32'd1);
    @(negedge clk);
    reqValid[2] = 1'b0;
    @(negedge clk);
    rstN[2] = 1'b0;
    #1;
    check("s5.rstReady", 32'(reqReady[2]), 32'd0);
    check("s5.rstStall", 32'(stallM[2]), 32'd0);
    check("s5.rstValid", 32'(rspValid[2]), 32'd0);
    check("s5.rstRdata", rspRdata[2], 32'd0);
    sawValid = 0;
    repeat (2) begin
      @(negedge clk);
      if (rspValid[2]) sawValid++;
    end
    rstN[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rspValid[2]) sawValid++;
    end
    check("s5.noRsp", sawValid, 0);
    doReq(2, "s5.lw", 1'b0, 32'h40, 32'd0, F_W, 32'h11111111, 1'b0);

    check("sb.drained", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
